// File: rtl/beam_thresh_loader.sv
`default_nettype none
// ============================================================================
// Module   : beam_thresh_loader
// Brief    : Write-side sequencer for the beam trigger threshold chain; fans
//            per-beam threshold writes onto a shared bus with per-beam CEs and
//            issues one common update strobe on commit.
// Revision : 1.0 - initial release
// ============================================================================
module beam_thresh_loader #(
  parameter int NDUAL   = 24,
  parameter int IDXW    = $clog2(2*NDUAL),
  parameter int OUT_REG = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [17:0]           wr_thresh_i,
  input  logic [IDXW-1:0]       wr_idx_i,
  input  logic                  wr_bcast_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic                  commit_i,
  output logic                  commit_ack_o,
  input  logic                  err_clr_i,
  output logic                  err_o,
  output logic                  busy_o,
  output logic [17:0]           thresh_o,
  output logic [2*NDUAL-1:0]    thresh_ce_o,
  output logic                  update_o
);

  localparam int              c_NBEAMS   = 2*NDUAL;
  localparam logic [IDXW:0]   c_NBEAMS_W = (IDXW+1)'(c_NBEAMS);

  localparam logic [1:0] S_IDLE        = 2'd0;
  localparam logic [1:0] S_COMMIT_WAIT = 2'd1;
  localparam logic [1:0] S_UPDATE      = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_next;
  logic                r_ready;
  logic                r_err;
  logic                w_ready;
  logic                w_acc;
  logic                w_invalid;
  logic                w_ce_busy;
  logic                w_out_ce_busy;
  logic                w_out_busy;
  logic                w_upd0;
  logic                w_fsm_busy;
  logic [c_NBEAMS-1:0] w_ce_dec;
  logic [c_NBEAMS-1:0] r_ce0;
  logic [17:0]         r_th0;

  // Ready is forced low while reset is held so nothing is accepted then.
  assign w_ready    = r_ready & ~rst_i;
  assign wr_ready_o = w_ready;
  assign w_acc      = wr_valid_i & w_ready;
  assign w_invalid  = ~wr_bcast_i & ({1'b0, wr_idx_i} >= c_NBEAMS_W);

  always_comb begin
    w_ce_dec = '0;
    if (wr_bcast_i) begin
      w_ce_dec = '1;
    end else if (!w_invalid) begin
      w_ce_dec[wr_idx_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ce0 <= '0;
      r_th0 <= '0;
      r_err <= 1'b0;
    end else begin
      r_ce0 <= w_acc ? w_ce_dec : '0;
      if (w_acc) begin
        r_th0 <= wr_thresh_i;
      end
      r_err <= (w_acc & w_invalid) | (r_err & ~err_clr_i);
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_IDLE);
    end
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:        if (commit_i)   w_next = S_COMMIT_WAIT;
      S_COMMIT_WAIT: if (!w_ce_busy) w_next = S_UPDATE;
      S_UPDATE:                      w_next = S_IDLE;
      default:                       w_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_upd0     = (r_state == S_UPDATE);
    w_fsm_busy = (r_state != S_IDLE);
  end

  assign w_ce_busy = (|r_ce0) | w_out_ce_busy;

  generate
    if (OUT_REG == 0) begin : g_out_direct
      assign thresh_o      = r_th0;
      assign thresh_ce_o   = r_ce0;
      assign update_o      = w_upd0;
      assign w_out_ce_busy = 1'b0;
      assign w_out_busy    = 1'b0;
    end else begin : g_out_pipe
      logic [OUT_REG-1:0][c_NBEAMS-1:0] r_ce_q;
      logic [OUT_REG-1:0][17:0]         r_th_q;
      logic [OUT_REG-1:0]               r_upd_q;

      // Update rides the same stages as the CEs so it can never overtake them.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_ce_q  <= '0;
          r_th_q  <= '0;
          r_upd_q <= '0;
        end else begin
          r_ce_q[0]  <= r_ce0;
          r_th_q[0]  <= r_th0;
          r_upd_q[0] <= w_upd0;
          for (int k = 1; k < OUT_REG; k++) begin
            r_ce_q[k]  <= r_ce_q[k-1];
            r_th_q[k]  <= r_th_q[k-1];
            r_upd_q[k] <= r_upd_q[k-1];
          end
        end
      end

      assign thresh_o      = r_th_q[OUT_REG-1];
      assign thresh_ce_o   = r_ce_q[OUT_REG-1];
      assign update_o      = r_upd_q[OUT_REG-1];
      assign w_out_ce_busy = |r_ce_q;
      assign w_out_busy    = w_out_ce_busy | (|r_upd_q);
    end
  endgenerate

  assign commit_ack_o = update_o;
  assign err_o        = r_err;
  assign busy_o       = w_fsm_busy | (|r_ce0) | w_out_busy;

endmodule
`default_nettype wire

// File: tb/tb_beam_thresh_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_beam_thresh_loader
// Brief    : Scoreboard bench for beam_thresh_loader: directed and random
//            writes/commits/resets against a cycle-level port-event model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_beam_thresh_loader;

  localparam int NDUAL = 24;
  localparam int NB    = 2*NDUAL;
  localparam int IDXW  = $clog2(NB);
  localparam int R     = 1;

  logic            clk;
  logic            rst_i;
  logic [17:0]     wr_thresh_i;
  logic [IDXW-1:0] wr_idx_i;
  logic            wr_bcast_i;
  logic            wr_valid_i;
  logic            wr_ready_o;
  logic            commit_i;
  logic            commit_ack_o;
  logic            err_clr_i;
  logic            err_o;
  logic            busy_o;
  logic [17:0]     thresh_o;
  logic [NB-1:0]   thresh_ce_o;
  logic            update_o;

  beam_thresh_loader #(.NDUAL(NDUAL), .IDXW(IDXW), .OUT_REG(R)) dut (
    .clk_i(clk), .rst_i(rst_i), .wr_thresh_i(wr_thresh_i), .wr_idx_i(wr_idx_i),
    .wr_bcast_i(wr_bcast_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .commit_i(commit_i), .commit_ack_o(commit_ack_o), .err_clr_i(err_clr_i),
    .err_o(err_o), .busy_o(busy_o), .thresh_o(thresh_o),
    .thresh_ce_o(thresh_ce_o), .update_o(update_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [NB-1:0] ce;
    logic [17:0]   th;
    bit            upd;
  } ev_t;

  ev_t q[$];
  int  cyc;
  int  n_chk;
  int  n_err;
  bit  mon_en;
  bit  chk_en;
  // Model: ready low through m_ready_low_until, FSM busy through m_fsm_until.
  int  m_ready_low_until;
  int  m_fsm_until;
  int  m_lastP;
  bit  m_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missed_event_cyc", 64'(cyc), 64'(q[0].cyc));
        void'(q.pop_front());
      end
      if (thresh_ce_o != '0 || update_o || commit_ack_o) begin
        if (q.size() == 0 || q[0].cyc != cyc) begin
          chk("unexpected_output", 64'({update_o, commit_ack_o, thresh_ce_o}), 64'd0);
        end else begin
          ev_t e;
          e = q.pop_front();
          chk("ce", 64'(thresh_ce_o), 64'(e.ce));
          if (e.ce != '0) chk("thresh", 64'(thresh_o), 64'(e.th));
          chk("update", 64'(update_o), 64'(e.upd));
          chk("commit_ack", 64'(commit_ack_o), 64'(e.upd));
        end
      end
    end
  end

  task automatic step(input bit v, input int idx, input bit bc, input logic [17:0] th,
                      input bit cm, input bit clr, input bit rs);
    bit            exp_ready;
    bit            acc;
    bit            inval;
    int            u;
    ev_t           e;
    logic [NB-1:0] one;
    rst_i       = rs;
    wr_valid_i  = v;
    wr_idx_i    = IDXW'(idx);
    wr_bcast_i  = bc;
    wr_thresh_i = th;
    commit_i    = cm;
    err_clr_i   = clr;
    #1;
    exp_ready = !rs && (cyc > m_ready_low_until);
    if (chk_en) begin
      chk("wr_ready", 64'(wr_ready_o), 64'(exp_ready));
      chk("err", 64'(err_o), 64'(m_err));
    end
    if (rs) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc > cyc) q.delete(i);
      end
      m_err             = 1'b0;
      m_ready_low_until = cyc + 1;
      m_fsm_until       = cyc;
      m_lastP           = -100;
    end else begin
      acc   = v && exp_ready;
      inval = !bc && (idx >= NB);
      if (acc && !inval) begin
        one   = 1;
        e.cyc = cyc + 1 + R;
        e.ce  = bc ? {NB{1'b1}} : (one << idx);
        e.th  = th;
        e.upd = 1'b0;
        q.push_back(e);
        m_lastP = e.cyc;
      end
      if (cm && cyc > m_fsm_until) begin
        // Update reaches the port no sooner than commit+2+R, and two cycles after the last CE leaves.
        u = (cyc + 2 + R > m_lastP + 2 + R) ? cyc + 2 + R : m_lastP + 2 + R;
        e.cyc = u;
        e.ce  = '0;
        e.th  = '0;
        e.upd = 1'b1;
        q.push_back(e);
        m_ready_low_until = u - R;
        m_fsm_until       = u - R;
      end
      m_err = (acc && inval) || (m_err && !clr);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 18'h0, 0, 0, 0);
  endtask

  initial begin
    n_chk = 0; n_err = 0; cyc = 0; mon_en = 0; chk_en = 0;
    m_err = 0; m_ready_low_until = 0; m_fsm_until = 0; m_lastP = -100;
    rst_i = 1; wr_thresh_i = '0; wr_idx_i = '0; wr_bcast_i = 0;
    wr_valid_i = 0; commit_i = 0; err_clr_i = 0;

    step(0, 0, 0, 18'h0, 0, 0, 1);
    chk_en = 1; mon_en = 1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 18'h0, 0, 0, 1);

    chk("rst_thresh", 64'(thresh_o), 64'd0);
    chk("rst_ce", 64'(thresh_ce_o), 64'd0);
    chk("rst_update", 64'(update_o), 64'd0);
    chk("rst_ack", 64'(commit_ack_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    idle(6);

    step(1, 5, 0, 18'h13880, 0, 0, 0);
    idle(4);

    step(1, 0, 0, 18'h00111, 0, 0, 0);
    step(1, 1, 0, 18'h00222, 0, 0, 0);
    step(1, 47, 0, 18'h00333, 0, 0, 0);
    step(0, 0, 0, 18'h0, 1, 0, 0);
    chk("busy_commit", 64'(busy_o), 64'd1);
    idle(8);

    step(1, 3, 0, 18'h00FFF, 1, 0, 0);
    idle(8);

    step(1, 0, 1, 18'h3FFFF, 0, 0, 0);
    idle(4);
    chk("bcast_hold", 64'(thresh_o), 64'h3FFFF);
    chk("busy_idle", 64'(busy_o), 64'd0);
    step(0, 0, 0, 18'h0, 1, 0, 0);
    idle(6);

    step(1, 48, 0, 18'h00001, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 18'h0, 0, 1, 0);
    idle(2);
    step(1, 49, 0, 18'h00002, 0, 0, 0);
    step(1, 50, 0, 18'h00003, 0, 1, 0);
    idle(2);
    step(0, 0, 0, 18'h0, 0, 1, 0);
    idle(2);

    step(0, 0, 0, 18'h0, 1, 0, 0);
    step(0, 0, 0, 18'h0, 1, 0, 0);
    step(0, 0, 0, 18'h0, 1, 0, 0);
    idle(6);

    step(1, 10, 0, 18'h0AAAA, 0, 0, 0);
    step(1, 20, 0, 18'h15555, 0, 0, 0);
    step(1, 30, 0, 18'h01234, 1, 0, 0);
    step(0, 0, 0, 18'h0, 0, 0, 1);
    step(0, 0, 0, 18'h0, 0, 0, 1);
    idle(4);

    for (int i = 0; i < 600; i++) begin
      step(bit'($urandom_range(1)), int'($urandom_range(63)),
           ($urandom_range(9) == 0), 18'($urandom),
           ($urandom_range(11) == 0), ($urandom_range(15) == 0),
           ($urandom_range(99) == 0));
    end
    idle(12);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
